ascon_serial_loader: RTL and testbench

- Upstream front-end of the ASCON core inside the user project, driven directly from GPIO input pads.
- Deserializes bit-serial key, nonce, associated data and PT/CT streams into parallel registers.
- Qualifies the external start strobe and issues a single-cycle start pulse to the core, then tracks the core busy/ready handshake.
- Guarantees the core never sees a partially loaded operand or a start held for several cycles.

---
 rtl/ascon_pkg.sv | 28 ++
 rtl/ascon_serial_loader_if.sv | 43 ++++
 rtl/ascon_sipo_reg.sv | 40 ++++
 rtl/ascon_serial_loader.sv | 154 +++++++++++++++
 tb/tb_ascon_serial_loader.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ascon_pkg.sv
// Shared constants, helpers and FSM state type for the ASCON serial front-end.
package ascon_pkg;

  localparam int unsigned ASCON_K     = 128;
  localparam int unsigned ASCON_NW    = 128;
  localparam int unsigned ASCON_R     = 64;
  localparam int unsigned ASCON_L_DEF = 40;
  localparam int unsigned ASCON_Y_DEF = 104;

  // Longest of the four streams sets the serial frame length.
  function automatic int unsigned ascon_maxw(input int unsigned a, input int unsigned b,
                                             input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StLoaded,
    StBusy
  } ascon_state_e;

endpackage

// File: rtl/ascon_serial_loader_if.sv
// Pad-side serial inputs and core-side parallel outputs of the serial loader.
interface ascon_serial_loader_if
  import ascon_pkg::*;
#(
  parameter int unsigned K  = ASCON_K,
  parameter int unsigned NW = ASCON_NW,
  parameter int unsigned L  = ASCON_L_DEF,
  parameter int unsigned Y  = ASCON_Y_DEF
) ();

  logic          load_enxSI;
  logic          keyxSI;
  logic          noncexSI;
  logic          associated_dataxSI;
  logic          input_dataxSI;
  logic          decryptxSI;
  logic          ascon_startxSI;
  logic          core_readyxSI;
  logic [K-1:0]  key_o;
  logic [NW-1:0] nonce_o;
  logic [L-1:0]  ad_o;
  logic [Y-1:0]  data_o;
  logic          decrypt_o;
  logic          core_start_o;
  logic          loaded_o;
  logic          busy_o;
  logic          err_o;

  // Loader side.
  modport slave (
    input  load_enxSI, keyxSI, noncexSI, associated_dataxSI, input_dataxSI,
    input  decryptxSI, ascon_startxSI, core_readyxSI,
    output key_o, nonce_o, ad_o, data_o, decrypt_o, core_start_o, loaded_o, busy_o, err_o
  );

  // Driver side (pads / bench).
  modport master (
    output load_enxSI, keyxSI, noncexSI, associated_dataxSI, input_dataxSI,
    output decryptxSI, ascon_startxSI, core_readyxSI,
    input  key_o, nonce_o, ad_o, data_o, decrypt_o, core_start_o, loaded_o, busy_o, err_o
  );

endinterface

// File: rtl/ascon_sipo_reg.sv
// Serial-in parallel-out register; shifts only while the frame index is inside its width.
module ascon_sipo_reg #(
  parameter int unsigned W    = 8,
  parameter int unsigned IdxW = 7
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic            bit_i,
  input  logic [IdxW-1:0] idx_i,
  output logic [W-1:0]    q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;
  logic [W-1:0] shifted;

  generate
    if (W == 1) begin : g_single
      assign shifted = bit_i;
    end else begin : g_multi
      assign shifted = {q_q[W-2:0], bit_i};
    end
  endgenerate

  // Accept the bit only for frame positions this stream actually owns.
  always_comb begin
    q_d = q_q;
    if (en_i && (32'(idx_i) < W)) q_d = shifted;
  end

  // Operand storage with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/ascon_serial_loader.sv
// Serial operand loader and start/busy handshake in front of the ASCON core.
module ascon_serial_loader
  import ascon_pkg::*;
#(
  parameter int unsigned K  = ASCON_K,
  parameter int unsigned NW = ASCON_NW,
  parameter int unsigned L  = ASCON_L_DEF,
  parameter int unsigned Y  = ASCON_Y_DEF
) (
  input logic                  clk,
  input logic                  rst,
  ascon_serial_loader_if.slave bus_io
);

  localparam int unsigned MaxW = ascon_maxw(K, NW, L, Y);
  localparam int unsigned CntW = (MaxW > 1) ? $clog2(MaxW) : 1;

  ascon_state_e    state_q, state_d;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
  logic            start_q;
  logic            loaded_q, loaded_d;
  logic            busy_q, busy_d;
  logic            core_start_q, core_start_d;
  logic            err_q, err_d;
  logic            decrypt_q, decrypt_d;
  logic            shift_en;
  logic [CntW-1:0] shift_idx;
  logic            rise;

  assign rise = bus_io.ascon_startxSI & ~start_q;

  // Next-state, counter and flag logic.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    loaded_d     = loaded_q;
    busy_d       = busy_q;
    core_start_d = 1'b0;
    err_d        = err_q;
    decrypt_d    = decrypt_q;
    shift_en     = 1'b0;
    shift_idx    = bit_cnt_q;
    unique case (state_q)
      StIdle, StShift: begin
        if (rise) err_d = 1'b1;
        if (bus_io.load_enxSI) begin
          shift_en = 1'b1;
          if (bit_cnt_q == CntW'(MaxW - 1)) begin
            bit_cnt_d = '0;
            loaded_d  = 1'b1;
            state_d   = StLoaded;
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
            state_d   = StShift;
          end
        end
      end
      StLoaded: begin
        // Start has priority; a coincident serial bit is silently dropped.
        if (rise) begin
          core_start_d = 1'b1;
          busy_d       = 1'b1;
          decrypt_d    = bus_io.decryptxSI;
          state_d      = StBusy;
        end else if (bus_io.load_enxSI) begin
          shift_en  = 1'b1;
          shift_idx = '0;
          if (MaxW == 1) begin
            bit_cnt_d = '0;
          end else begin
            loaded_d  = 1'b0;
            bit_cnt_d = CntW'(1);
            state_d   = StShift;
          end
        end
      end
      StBusy: begin
        if (bus_io.load_enxSI) err_d = 1'b1;
        // Ready seen alongside our own start pulse belongs to a previous run.
        if (bus_io.core_readyxSI && !core_start_q) begin
          busy_d  = 1'b0;
          state_d = StLoaded;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      start_q      <= 1'b0;
      loaded_q     <= 1'b0;
      busy_q       <= 1'b0;
      core_start_q <= 1'b0;
      err_q        <= 1'b0;
      decrypt_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      start_q      <= bus_io.ascon_startxSI;
      loaded_q     <= loaded_d;
      busy_q       <= busy_d;
      core_start_q <= core_start_d;
      err_q        <= err_d;
      decrypt_q    <= decrypt_d;
    end
  end

  ascon_sipo_reg #(.W(K), .IdxW(CntW)) u_key (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (shift_en),
    .bit_i (bus_io.keyxSI),
    .idx_i (shift_idx),
    .q_o   (bus_io.key_o)
  );

  ascon_sipo_reg #(.W(NW), .IdxW(CntW)) u_nonce (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (shift_en),
    .bit_i (bus_io.noncexSI),
    .idx_i (shift_idx),
    .q_o   (bus_io.nonce_o)
  );

  ascon_sipo_reg #(.W(L), .IdxW(CntW)) u_ad (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (shift_en),
    .bit_i (bus_io.associated_dataxSI),
    .idx_i (shift_idx),
    .q_o   (bus_io.ad_o)
  );

  ascon_sipo_reg #(.W(Y), .IdxW(CntW)) u_data (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (shift_en),
    .bit_i (bus_io.input_dataxSI),
    .idx_i (shift_idx),
    .q_o   (bus_io.data_o)
  );

  assign bus_io.decrypt_o    = decrypt_q;
  assign bus_io.core_start_o = core_start_q;
  assign bus_io.loaded_o     = loaded_q;
  assign bus_io.busy_o       = busy_q;
  assign bus_io.err_o        = err_q;

endmodule

// File: tb/tb_ascon_serial_loader.sv
// Directed + randomized bench for ascon_serial_loader with a per-cycle reference model.
module tb_ascon_serial_loader;
  import ascon_pkg::*;

  localparam int K = 128;
  localparam int NW = 128;
  localparam int L = 40;
  localparam int Y = 104;
  localparam int MAXW = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ascon_serial_loader_if #(.K(K), .NW(NW), .L(L), .Y(Y)) bus ();

  ascon_serial_loader #(.K(K), .NW(NW), .L(L), .Y(Y)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: frame progress and output flags.
  int m_bits = 0;
  bit m_loaded = 0, m_busy = 0, m_start = 0, m_err = 0, m_dec = 0, m_prev = 0;

  // Current frame contents.
  logic [K-1:0]  f_key;
  logic [NW-1:0] f_nonce;
  logic [L-1:0]  f_ad;
  logic [Y-1:0]  f_dat;

  int pulses;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock: update model from current inputs, then compare flags.
  task automatic cyc();
    bit rise;
    rise = bus.ascon_startxSI && !m_prev;
    if (rst) begin
      m_bits = 0; m_loaded = 0; m_busy = 0; m_start = 0; m_err = 0; m_dec = 0;
    end else if (m_busy) begin
      if (bus.load_enxSI) m_err = 1;
      if (bus.core_readyxSI && !m_start) m_busy = 0;
      m_start = 0;
    end else if (m_loaded) begin
      m_start = 0;
      if (rise) begin
        m_start = 1; m_busy = 1; m_dec = bus.decryptxSI;
      end else if (bus.load_enxSI) begin
        m_loaded = 0;
        m_bits = 1;
        if (m_bits == MAXW) begin m_bits = 0; m_loaded = 1; end
      end
    end else begin
      m_start = 0;
      if (rise) m_err = 1;
      if (bus.load_enxSI) begin
        m_bits++;
        if (m_bits == MAXW) begin m_bits = 0; m_loaded = 1; end
      end
    end
    m_prev = rst ? 1'b0 : bus.ascon_startxSI;
    @(posedge clk);
    #1;
    chk("loaded", bus.loaded_o, m_loaded);
    chk("busy", bus.busy_o, m_busy);
    chk("core_start", bus.core_start_o, m_start);
    chk("err", bus.err_o, m_err);
    chk("decrypt", bus.decrypt_o, m_dec);
  endtask

  task automatic chk_ops(input string tag);
    chk({tag, "_key"}, bus.key_o, f_key);
    chk({tag, "_nonce"}, bus.nonce_o, f_nonce);
    chk({tag, "_ad"}, bus.ad_o, f_ad);
    chk({tag, "_data"}, bus.data_o, f_dat);
  endtask

  task automatic rand_frame();
    f_key   = {$urandom, $urandom, $urandom, $urandom};
    f_nonce = {$urandom, $urandom, $urandom, $urandom};
    f_ad    = L'({$urandom, $urandom});
    f_dat   = Y'({$urandom, $urandom, $urandom, $urandom});
  endtask

  // Shift one MSB-first frame; positions past a stream's width carry random junk.
  task automatic drive_frame(input int gap_at, input int gap_len, input int st_at,
                             input int abort_at);
    for (int i = 0; i < MAXW; i++) begin
      if (i == abort_at) begin
        rst = 1; bus.load_enxSI = 0;
        cyc();
        rst = 0;
        return;
      end
      if (i == gap_at) begin
        bus.load_enxSI = 0;
        bus.ascon_startxSI = 0;
        for (int g = 0; g < gap_len; g++) begin
          cyc();
          chk("bit_cnt_gap", 128'(dut.bit_cnt_q), 128'(gap_at));
        end
      end
      bus.load_enxSI         = 1;
      bus.keyxSI             = (i < K)  ? f_key[K-1-i]   : 1'($urandom);
      bus.noncexSI           = (i < NW) ? f_nonce[NW-1-i] : 1'($urandom);
      bus.associated_dataxSI = (i < L)  ? f_ad[L-1-i]    : 1'($urandom);
      bus.input_dataxSI      = (i < Y)  ? f_dat[Y-1-i]   : 1'($urandom);
      bus.ascon_startxSI     = (i == st_at);
      cyc();
    end
    bus.load_enxSI = 0;
    bus.ascon_startxSI = 0;
  endtask

  initial begin
    bus.load_enxSI = 0; bus.keyxSI = 0; bus.noncexSI = 0; bus.associated_dataxSI = 0;
    bus.input_dataxSI = 0; bus.decryptxSI = 0; bus.ascon_startxSI = 0;
    bus.core_readyxSI = 0;

    // Reset state.
    rst = 1;
    cyc(); cyc();
    rst = 0;
    f_key = '0; f_nonce = '0; f_ad = '0; f_dat = '0;
    chk_ops("reset");

    // Encrypt load with the reference vectors.
    f_key   = 128'h6d4f8bbf60ec05a07b201d4e5b2119ac;
    f_nonce = 128'h05885e606e1271b8d47a74c7b297a318;
    f_ad    = 40'h4153434f4e;
    f_dat   = 104'h6173636f6e2d756e6963617373;
    drive_frame(-1, 0, -1, -1);
    chk("enc_loaded", bus.loaded_o, 1'b1);
    chk("enc_err", bus.err_o, 1'b0);
    chk_ops("enc");

    // Start held for 90 cycles: single pulse; ready during the pulse is ignored.
    bus.ascon_startxSI = 1; bus.decryptxSI = 0;
    pulses = 0;
    for (int c = 0; c < 90; c++) begin
      bus.core_readyxSI = (c == 1 || c == 20);
      cyc();
      if (bus.core_start_o) pulses++;
    end
    bus.core_readyxSI = 0; bus.ascon_startxSI = 0;
    chk("start_pulses", 128'(pulses), 128'd1);
    chk("hs_busy_done", bus.busy_o, 1'b0);
    chk("hs_loaded", bus.loaded_o, 1'b1);
    chk_ops("hs");

    // Decrypt frame with a 10-cycle pause at bit 60, then shift while busy.
    rand_frame();
    f_dat = 104'h18490112f8d5867a830748390b;
    drive_frame(60, 10, -1, -1);
    cyc();
    bus.ascon_startxSI = 1; bus.decryptxSI = 1;
    cyc();
    bus.ascon_startxSI = 0; bus.decryptxSI = 0;
    chk("dec_mode", bus.decrypt_o, 1'b1);
    bus.load_enxSI = 1;
    for (int c = 0; c < 5; c++) begin
      bus.keyxSI = 1'($urandom); bus.noncexSI = 1'($urandom);
      bus.associated_dataxSI = 1'($urandom); bus.input_dataxSI = 1'($urandom);
      cyc();
    end
    bus.load_enxSI = 0;
    chk("busy_shift_err", bus.err_o, 1'b1);
    chk_ops("busy_shift");

    // Reset while busy.
    rst = 1;
    cyc();
    rst = 0;
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_loaded", bus.loaded_o, 1'b0);
    f_key = '0; f_nonce = '0; f_ad = '0; f_dat = '0;
    chk_ops("rst_busy");

    // Premature start at bit 50: flagged, load still completes, then a real start.
    rand_frame();
    drive_frame(-1, 0, 50, -1);
    chk("premature_err", bus.err_o, 1'b1);
    chk_ops("premature");
    bus.ascon_startxSI = 1;
    cyc();
    bus.ascon_startxSI = 0;
    cyc();
    bus.core_readyxSI = 1;
    cyc();
    bus.core_readyxSI = 0;
    cyc();

    // Reset at bit 70, then a complete reload.
    rst = 1;
    cyc();
    rst = 0;
    rand_frame();
    drive_frame(-1, 0, -1, 70);
    rand_frame();
    drive_frame(-1, 0, -1, -1);
    chk("reload_err", bus.err_o, 1'b0);
    chk_ops("reload");

    // Start and shift together in LOADED: start wins, no error, operands kept.
    bus.ascon_startxSI = 1; bus.load_enxSI = 1;
    bus.keyxSI = ~f_key[K-1]; bus.noncexSI = ~f_nonce[NW-1];
    bus.associated_dataxSI = ~f_ad[L-1]; bus.input_dataxSI = ~f_dat[Y-1];
    cyc();
    bus.ascon_startxSI = 0; bus.load_enxSI = 0;
    chk("simul_start", bus.core_start_o, 1'b1);
    chk("simul_err", bus.err_o, 1'b0);
    chk_ops("simul");
    cyc();
    bus.core_readyxSI = 1;
    cyc();
    bus.core_readyxSI = 0;

    // Randomized frames with random pauses and random mode.
    for (int n = 0; n < 4; n++) begin
      rand_frame();
      drive_frame($urandom_range(1, 126), $urandom_range(1, 5), -1, -1);
      chk_ops("rand");
      bus.ascon_startxSI = 1; bus.decryptxSI = 1'($urandom);
      cyc();
      bus.ascon_startxSI = 0;
      repeat ($urandom_range(2, 6)) cyc();
      bus.core_readyxSI = 1;
      cyc();
      bus.core_readyxSI = 0;
      cyc();
      chk_ops("rand_after");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
